// File: rtl/branch_predict_unit.sv
// Branch resolve + dynamic prediction: direct-mapped BTB with 2-bit counters, EX mispredict/redirect, stats.
// Latency: fetch lookup and EX resolve are combinational; table and counter updates land on the next rising edge.
// Backpressure: none; a resolved instruction is accepted every cycle it is presented.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   f_pc                  fetch PC -> f_pred_taken / f_pred_target
//   ex_*                  EX-stage instruction, its resolved condition/target and the prediction it carried
//   pc_imm, pc_four       ex_pc + imm and ex_pc + 4 (32-bit, ex_pc zero-extended)
//   br_pc, pc_sel         redirect target and select (0 target when no redirect)
//   mispredict            same as pc_sel, used for the IF/ID flush
//   branch_cnt            saturating count of resolved control-flow instructions
//   mispred_cnt           saturating count of mispredicts
module branch_predict_unit #(
  parameter int PC_W  = 8,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  f_pc,
  output logic             f_pred_taken,
  output logic [PC_W-1:0]  f_pred_target,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic             ex_branch,
  input  logic             ex_jalr,
  input  logic [31:0]      ex_alu_result,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic [31:0]      pc_imm,
  output logic [31:0]      pc_four,
  output logic [31:0]      br_pc,
  output logic             pc_sel,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;

  // Prediction table state
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [PC_W-1:0]  target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  // Statistics
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_d;

  // ------------------------------------------------------------------
  // Fetch lookup: reads registered state only, so an EX write in the
  // same cycle is not visible until the following cycle.
  // ------------------------------------------------------------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  always_comb begin
    f_idx         = f_pc[IDX_W+1:2];
    f_tag         = f_pc[PC_W-1:IDX_W+2];
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    f_pred_taken  = f_hit && ctr_q[f_idx][1];
    f_pred_target = f_pred_taken ? target_q[f_idx] : f_pc + PC_W'(4);
  end

  // ------------------------------------------------------------------
  // EX resolve
  // ------------------------------------------------------------------
  logic [31:0] pc_ext;
  logic [31:0] act_tgt;
  logic        cf;
  logic        act_taken;
  logic        tgt_wrong;
  logic        stale_alias;

  always_comb begin
    pc_ext    = 32'(ex_pc);
    pc_imm    = pc_ext + ex_imm;
    pc_four   = pc_ext + 32'd4;
    cf        = ex_valid && (ex_branch || ex_jalr);
    // jalr takes priority over a simultaneously flagged branch
    act_taken = ex_jalr || (ex_branch && ex_alu_result[0]);
    act_tgt   = ex_jalr ? ex_alu_result : pc_imm;
    tgt_wrong = act_taken && (ex_pred_target != act_tgt[PC_W-1:0]);
    // A non-control-flow instruction predicted taken hit an aliased entry;
    // fetch went somewhere wrong, so fall through to pc+4.
    stale_alias = ex_valid && !ex_branch && !ex_jalr && ex_pred_taken;
    mispredict  = (cf && ((ex_pred_taken != act_taken) || tgt_wrong)) || stale_alias;
    pc_sel      = mispredict;
    br_pc       = !mispredict ? 32'd0 : (act_taken ? act_tgt : pc_four);
  end

  // ------------------------------------------------------------------
  // Training and statistics next-state
  // ------------------------------------------------------------------
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      ctr_d[i]    = ctr_q[i];
    end
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    ex_idx = ex_pc[IDX_W+1:2];
    ex_tag = ex_pc[PC_W-1:IDX_W+2];
    ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    if (cf) begin
      if (act_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = act_tgt[PC_W-1:0];
        if (ex_hit) begin
          ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
        end else begin
          // New owner of the slot starts weakly taken
          ctr_d[ex_idx] = 2'b10;
        end
      end else if (ex_hit) begin
        ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
      end
      // Not taken and not ours: leave the other branch's entry alone
    end else if (stale_alias) begin
      valid_d[ex_idx] = 1'b0;
    end

    if (cf && (branch_cnt_q != {CNT_W{1'b1}})) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispredict && (mispred_cnt_q != {CNT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
